// File: rtl/deferred_control.sv
// deferred_control: batches per-cycle difftest commit step counts into
// deferred check requests for the host checker, and keeps the checker's
// first nonzero verdict as a sticky simv_result for the simulation endpoint.
//
// Optional feature: define DEFERRED_CONTROL_TIMEOUT_EN to add an idle timer
// that flushes a partial batch after TIMEOUT_CYCLES counted cycles. Without
// the macro, requests are issued only when the threshold is reached, and any
// residue below the threshold is never requested.
module deferred_control #(
  parameter int unsigned STEP_WIDTH      = 8,
  parameter int unsigned COUNT_WIDTH     = 32,
  parameter int unsigned FLUSH_THRESHOLD = 4096,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [STEP_WIDTH-1:0]  step,
  output logic                   flush_valid,
  output logic [COUNT_WIDTH-1:0] flush_count,
  input  logic                   flush_ready,
  input  logic                   result_valid,
  input  logic [7:0]             result_code,
  output logic [7:0]             simv_result
);

  // A zero threshold or zero timeout would allow empty requests.
  if (FLUSH_THRESHOLD < 1) begin : g_bad_threshold
    $error("deferred_control: FLUSH_THRESHOLD must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("deferred_control: TIMEOUT_CYCLES must be at least 1");
  end
  if (STEP_WIDTH > COUNT_WIDTH) begin : g_bad_widths
    $error("deferred_control: STEP_WIDTH must not exceed COUNT_WIDTH");
  end

  localparam logic [COUNT_WIDTH-1:0] THRESHOLD = COUNT_WIDTH'(FLUSH_THRESHOLD);

  // Steps committed but not yet covered by an issued request.
  logic [COUNT_WIDTH-1:0] acc;

  // Combinational view of this cycle's decision.
  logic [COUNT_WIDTH:0]   acc_sum;
  logic [COUNT_WIDTH-1:0] acc_next;
  logic                   threshold_hit;
  logic                   timeout_hit;
  logic                   handshake;
  logic                   frozen;
  logic                   issue;

  // Saturating accumulate: the carry-out bit selects the all-ones ceiling.
  assign acc_sum  = {1'b0, acc} + (COUNT_WIDTH + 1)'(step);
  assign acc_next = acc_sum[COUNT_WIDTH] ? {COUNT_WIDTH{1'b1}} : acc_sum[COUNT_WIDTH-1:0];

  assign threshold_hit = (acc_next >= THRESHOLD);
  assign handshake     = flush_valid && flush_ready;

  // Once a verdict is latched the batch is finished: no new requests and
  // the accumulator stops moving. An outstanding request may still drain.
  assign frozen = (simv_result != 8'h00);

`ifdef DEFERRED_CONTROL_TIMEOUT_EN
  localparam int unsigned TIMER_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMER_WIDTH-1:0] idle_timer;

  // The cycle in which the timer sits at its last value is the
  // TIMEOUT_CYCLES-th counted cycle, so the partial flush fires then.
  assign timeout_hit = (acc != '0) && (idle_timer == TIMER_LAST);

  // Count cycles that hold residual steps without issuing; saturate so a
  // long-pending request does not wrap the timer.
  always_ff @(posedge clock) begin
    if (reset) begin
      idle_timer <= '0;
    end else if (issue) begin
      idle_timer <= '0;
    end else if ((acc != '0) && (idle_timer != TIMER_LAST)) begin
      idle_timer <= idle_timer + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // A request is issued either from the idle state (threshold or timeout)
  // or back-to-back in the handshake cycle when the threshold is met again.
  // The timeout only applies when nothing is pending.
  always_comb begin
    issue = 1'b0;
    if (!frozen) begin
      if (!flush_valid) begin
        issue = threshold_hit || timeout_hit;
      end else if (handshake) begin
        issue = threshold_hit;
      end
    end
  end

  // Request register and accumulator: a pending request is held stable
  // until accepted while new steps keep accumulating behind it.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc         <= '0;
      flush_valid <= 1'b0;
      flush_count <= '0;
    end else begin
      if (issue) begin
        flush_valid <= 1'b1;
        flush_count <= acc_next;
      end else if (handshake) begin
        flush_valid <= 1'b0;
        flush_count <= '0;
      end

      if (issue) begin
        acc <= '0;
      end else if (!frozen) begin
        acc <= acc_next;
      end
    end
  end

  // Sticky verdict: only the first nonzero code is kept until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      simv_result <= 8'h00;
    end else if (result_valid && (result_code != 8'h00) && (simv_result == 8'h00)) begin
      simv_result <= result_code;
    end
  end

endmodule

// File: tb/tb_deferred_control.sv
// Self-checking bench for deferred_control: directed scenarios plus a
// randomized run, all compared against a behavioural model of the batching
// rules. Build with DEFERRED_CONTROL_TIMEOUT_EN to exercise the idle timer.
module tb_deferred_control;

  localparam int unsigned SW = 8;
  localparam int unsigned CW = 32;
  localparam int unsigned TH = 4096;
  localparam int unsigned TO = 16;
  localparam longint      SAT_MAX = 64'h0000_0000_FFFF_FFFF;

  logic          clock = 1'b0;
  logic          reset;
  logic [SW-1:0] step;
  logic          flush_valid;
  logic [CW-1:0] flush_count;
  logic          flush_ready;
  logic          result_valid;
  logic [7:0]    result_code;
  logic [7:0]    simv_result;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: outstanding steps, the pending request and the verdict.
  longint m_acc;
  bit     m_pending;
  longint m_count;
  int     m_simv;
  longint m_idle;

  deferred_control #(
    .STEP_WIDTH(SW),
    .COUNT_WIDTH(CW),
    .FLUSH_THRESHOLD(TH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .step(step),
    .flush_valid(flush_valid),
    .flush_count(flush_count),
    .flush_ready(flush_ready),
    .result_valid(result_valid),
    .result_code(result_code),
    .simv_result(simv_result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Apply one clock edge of the batching rules to the model.
  task automatic model_update();
    longint total;
    bit     frozen;
    bit     over;
    bit     timed_out;
    bit     accepted;
    bit     fire;
    if (reset) begin
      m_acc = 0; m_pending = 0; m_count = 0; m_simv = 0; m_idle = 0;
    end else begin
      total = m_acc + longint'(step);
      if (total > SAT_MAX) total = SAT_MAX;
      frozen    = (m_simv != 0);
      over      = (total >= TH);
      timed_out = 0;
`ifdef DEFERRED_CONTROL_TIMEOUT_EN
      timed_out = (m_acc != 0) && (m_idle + 1 >= TO);
`endif
      accepted = m_pending && flush_ready;
      fire = !frozen && ((!m_pending && (over || timed_out)) || (accepted && over));
      if (fire) m_idle = 0;
      else if (m_acc != 0) m_idle++;
      if (fire) begin
        m_pending = 1; m_count = total; m_acc = 0;
      end else begin
        if (accepted) begin
          m_pending = 0; m_count = 0;
        end
        if (!frozen) m_acc = total;
      end
      if (result_valid && result_code != 0 && m_simv == 0) m_simv = result_code;
    end
  endtask

  // One transaction: drive inputs, clock, then compare against the model.
  task automatic cyc(input logic [SW-1:0] s, input bit rdy, input bit rv, input logic [7:0] rc);
    step = s; flush_ready = rdy; result_valid = rv; result_code = rc;
    @(posedge clock);
    model_update();
    #1;
    check("flush_valid", flush_valid, m_pending);
    if (m_pending) check("flush_count", flush_count, m_count);
    check("simv_result", simv_result, m_simv);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    reset = 1'b0;
  endtask

  int first_seen;

  initial begin
    reset = 1'b1; step = '0; flush_ready = 1'b0; result_valid = 1'b0; result_code = 8'h00;
    m_acc = 0; m_pending = 0; m_count = 0; m_simv = 0; m_idle = 0;

    // Reset state
    do_reset();
    check("rst_valid", flush_valid, 0);
    check("rst_count", flush_count, 0);
    check("rst_simv", simv_result, 0);

    // Threshold: step=8 with ready -> request right after the 512th cycle
    for (int i = 0; i < 512; i++) begin
      cyc(8, 1, 0, 0);
`ifndef DEFERRED_CONTROL_TIMEOUT_EN
      if (i == 510) check("thr_early", flush_valid, 0);
`endif
    end
`ifndef DEFERRED_CONTROL_TIMEOUT_EN
    check("thr_valid", flush_valid, 1);
    check("thr_count", flush_count, 4096);
`endif
    cyc(0, 1, 0, 0);
`ifndef DEFERRED_CONTROL_TIMEOUT_EN
    check("thr_drop", flush_valid, 0);
`endif

    // Backpressure: held request stays stable while 100 extra steps arrive
    do_reset();
    for (int i = 0; i < 512; i++) cyc(8, 0, 0, 0);
    for (int i = 0; i < 100; i++) cyc(1, 0, 0, 0);
    check("bp_hold_valid", flush_valid, 1);
`ifndef DEFERRED_CONTROL_TIMEOUT_EN
    check("bp_hold_count", flush_count, 4096);
`endif
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 500; i++) cyc(8, 1, 0, 0);
`ifndef DEFERRED_CONTROL_TIMEOUT_EN
    check("bp_next_count", flush_count, 4100);
`endif
    cyc(0, 1, 0, 0);

    // Zero verdict is ignored
    cyc(50, 1, 1, 8'h00);
    check("zero_code", simv_result, 0);

    // Randomized traffic with occasional zero verdicts
    for (int i = 0; i < 3000; i++) begin
      logic [SW-1:0] s;
      s = ($urandom_range(0, 3) == 0) ? '0 : SW'($urandom_range(0, 255));
      cyc(s, bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 8'h00);
    end

    // Sticky verdict: FAIL code latches, later DONE ignored, no new requests
    cyc(8, 0, 1, 8'h02);
    check("verdict_fail", simv_result, 8'h02);
    cyc(200, 1, 1, 8'h01);
    check("verdict_sticky", simv_result, 8'h02);
    for (int i = 0; i < 40; i++) cyc(255, 1, 0, 0);
    check("verdict_no_flush", flush_valid, 0);

    // Reset while a request and a verdict are outstanding
    do_reset();
    for (int i = 0; i < 20; i++) cyc(255, 0, 0, 0);
    check("mid_pending", flush_valid, 1);
    cyc(0, 0, 1, 8'h02);
    reset = 1'b1;
    cyc(0, 0, 0, 0);
    reset = 1'b0;
    check("mid_rst_valid", flush_valid, 0);
    check("mid_rst_count", flush_count, 0);
    check("mid_rst_simv", simv_result, 0);

    // Residual steps: timeout flush with the macro, never without
    do_reset();
    cyc(5, 1, 0, 0);
    first_seen = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0, 0);
      if (flush_valid && first_seen == 0) first_seen = i + 1;
    end
`ifdef DEFERRED_CONTROL_TIMEOUT_EN
    check("timeout_cycle", first_seen, 16);
    check("timeout_count", flush_count, 5);
`else
    check("no_timeout", first_seen, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
